// File: rtl/mcpu_alu.sv
// mcpu_alu: four-function ALU (AND/OR/XOR/ADD) with registered result and
// ADD carry-out. One new operation per cycle, one-cycle latency.
module mcpu_alu #(
  parameter int unsigned CMD_SIZE  = 2,
  parameter int unsigned WORD_SIZE = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [CMD_SIZE-1:0]  opcode,
  input  logic [WORD_SIZE-1:0] r1,
  input  logic [WORD_SIZE-1:0] r2,
  output logic [WORD_SIZE-1:0] out,
  output logic                 OVERFLOW
);

  localparam int unsigned SUM_W = WORD_SIZE + 1;

  localparam logic [CMD_SIZE-1:0] CMD_AND = CMD_SIZE'(0);
  localparam logic [CMD_SIZE-1:0] CMD_OR  = CMD_SIZE'(1);
  localparam logic [CMD_SIZE-1:0] CMD_XOR = CMD_SIZE'(2);

  logic [SUM_W-1:0]     sum_c;
  logic [WORD_SIZE-1:0] result_c;
  logic                 carry_c;

  // Opcode decode; ADD and every unlisted opcode share the adder path.
  always_comb begin
    sum_c    = SUM_W'(r1) + SUM_W'(r2);
    result_c = sum_c[WORD_SIZE-1:0];
    carry_c  = sum_c[WORD_SIZE];
    case (opcode)
      CMD_AND: begin
        result_c = r1 & r2;
        carry_c  = 1'b0;
      end
      CMD_OR: begin
        result_c = r1 | r2;
        carry_c  = 1'b0;
      end
      CMD_XOR: begin
        result_c = r1 ^ r2;
        carry_c  = 1'b0;
      end
      default: begin
        result_c = sum_c[WORD_SIZE-1:0];
        carry_c  = sum_c[WORD_SIZE];
      end
    endcase
  end

  // Output registers; reset discards whatever operation is in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      out      <= '0;
      OVERFLOW <= 1'b0;
    end else begin
      out      <= result_c;
      OVERFLOW <= carry_c;
    end
  end

endmodule

// File: tb/tb_mcpu_alu.sv
// Bench for mcpu_alu at WORD_SIZE=2, CMD_SIZE=2: directed scenarios plus a
// randomized run against an arithmetic reference model.
module tb_mcpu_alu;

  localparam int unsigned CW = 2;
  localparam int unsigned WW = 2;

  logic          clk;
  logic          reset;
  logic [CW-1:0] opcode;
  logic [WW-1:0] r1;
  logic [WW-1:0] r2;
  logic [WW-1:0] out;
  logic          OVERFLOW;

  int total;
  int bad;

  mcpu_alu #(.CMD_SIZE(CW), .WORD_SIZE(WW)) dut (
    .clk     (clk),
    .reset   (reset),
    .opcode  (opcode),
    .r1      (r1),
    .r2      (r2),
    .out     (out),
    .OVERFLOW(OVERFLOW)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: integer arithmetic on the opcode meaning.
  function automatic void model(input int op, input int a, input int b,
                                output int eo, output int ev);
    int s;
    if (op == 0) begin
      eo = a & b; ev = 0;
    end else if (op == 1) begin
      eo = a | b; ev = 0;
    end else if (op == 2) begin
      eo = a ^ b; ev = 0;
    end else begin
      s  = a + b;
      eo = s % (1 << WW);
      ev = s / (1 << WW);
    end
  endfunction

  // Apply inputs away from the edge, then settle just after the capturing edge.
  task automatic do_cycle(input logic rst, input int op, input int a, input int b);
    @(negedge clk);
    reset  = rst;
    opcode = CW'(op);
    r1     = WW'(a);
    r2     = WW'(b);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      do_cycle(1'b1, 3, 3, 3);
      total++;
      if (out !== 2'd0 || OVERFLOW !== 1'b0) begin
        bad++;
        $display("FAIL reset_hold[%0d] got out=%0d ov=%0b want out=0 ov=0", i, out, OVERFLOW);
      end
    end
    do_cycle(1'b0, 3, 3, 3);
    total++;
    if (out !== 2'd2 || OVERFLOW !== 1'b1) begin
      bad++;
      $display("FAIL reset_release got out=%0d ov=%0b want out=2 ov=1", out, OVERFLOW);
    end
  endtask

  task automatic test_logic_ops();
    logic [WW-1:0] want [3];
    want[0] = 2'b10; want[1] = 2'b11; want[2] = 2'b01;
    for (int op = 0; op < 3; op++) begin
      do_cycle(1'b0, op, 2, 3);
      total++;
      if (out !== want[op] || OVERFLOW !== 1'b0) begin
        bad++;
        $display("FAIL logic_op%0d got out=%0d ov=%0b want out=%0d ov=0", op, out, OVERFLOW, want[op]);
      end
    end
  endtask

  task automatic test_add();
    int a [3];
    int b [3];
    int eo [3];
    int ev [3];
    a[0] = 1; b[0] = 2; eo[0] = 3; ev[0] = 0;
    a[1] = 3; b[1] = 1; eo[1] = 0; ev[1] = 1;
    a[2] = 2; b[2] = 2; eo[2] = 0; ev[2] = 1;
    for (int i = 0; i < 3; i++) begin
      do_cycle(1'b0, 3, a[i], b[i]);
      total++;
      if (int'(out) !== eo[i] || int'(OVERFLOW) !== ev[i]) begin
        bad++;
        $display("FAIL add[%0d] %0d+%0d got out=%0d ov=%0b want out=%0d ov=%0d",
                 i, a[i], b[i], out, OVERFLOW, eo[i], ev[i]);
      end
    end
  endtask

  task automatic test_midstream_reset();
    logic [2:0] rst_seq;
    int eo;
    int ev;
    rst_seq = 3'b010;
    for (int i = 0; i < 3; i++) begin
      do_cycle(rst_seq[2-i], 3, 3, 3);
      eo = rst_seq[2-i] ? 0 : 2;
      ev = rst_seq[2-i] ? 0 : 1;
      total++;
      if (int'(out) !== eo || int'(OVERFLOW) !== ev) begin
        bad++;
        $display("FAIL midreset[%0d] got out=%0d ov=%0b want out=%0d ov=%0d", i, out, OVERFLOW, eo, ev);
      end
    end
  endtask

  // Distinct opcode every cycle; also confirms outputs hold when inputs move mid-cycle.
  task automatic test_back_to_back();
    int ops [4];
    int eo;
    int ev;
    ops[0] = 3; ops[1] = 0; ops[2] = 2; ops[3] = 1;
    for (int i = 0; i < 4; i++) begin
      do_cycle(1'b0, ops[i], 3, 1);
      model(ops[i], 3, 1, eo, ev);
      total++;
      if (int'(out) !== eo || int'(OVERFLOW) !== ev) begin
        bad++;
        $display("FAIL b2b[%0d] op=%0d got out=%0d ov=%0b want out=%0d ov=%0d",
                 i, ops[i], out, OVERFLOW, eo, ev);
      end
      opcode = CW'(3 - ops[i]);
      r1     = 2'd2;
      r2     = 2'd2;
      #2;
      total++;
      if (int'(out) !== eo || int'(OVERFLOW) !== ev) begin
        bad++;
        $display("FAIL b2b_hold[%0d] got out=%0d ov=%0b want out=%0d ov=%0d", i, out, OVERFLOW, eo, ev);
      end
    end
  endtask

  task automatic test_random();
    int op;
    int a;
    int b;
    int eo;
    int ev;
    for (int i = 0; i < 1000; i++) begin
      op = int'($urandom_range(3, 0));
      a  = int'($urandom_range(3, 0));
      b  = int'($urandom_range(3, 0));
      do_cycle(1'b0, op, a, b);
      model(op, a, b, eo, ev);
      total++;
      if (int'(out) !== eo || int'(OVERFLOW) !== ev) begin
        bad++;
        $display("FAIL random[%0d] op=%0d a=%0d b=%0d got out=%0d ov=%0b want out=%0d ov=%0d",
                 i, op, a, b, out, OVERFLOW, eo, ev);
      end
    end
  endtask

  initial begin
    total  = 0;
    bad    = 0;
    reset  = 1'b1;
    opcode = '0;
    r1     = '0;
    r2     = '0;
    test_reset();
    test_logic_ops();
    test_add();
    test_midstream_reset();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mcpu_alu.md
# mcpu_alu

Parameterised ALU for the MCPU datapath. Each cycle it applies one of four operations, AND, OR, XOR or ADD, to two operand words. The result and an ADD carry-out flag are registered on the rising clock edge. It sits between the register file read ports and the writeback path and is driven directly by the decoded opcode field.

## Interface

Parameters:
- CMD_SIZE, default 2: opcode width in bits; must be at least 2.
- WORD_SIZE, default 2: operand and result width in bits; must be at least 1.

Ports, in this positional order:
- clk  input  1  system clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
- opcode  input  CMD_SIZE  operation select.
- r1  input  WORD_SIZE  operand A.
- r2  input  WORD_SIZE  operand B.
- out  output  WORD_SIZE  registered result.
- OVERFLOW  output  1  registered carry-out of ADD; 0 for the logic operations.

The block has one clock. Reset is synchronous and active-high.

## Operation

Opcode decode uses the full CMD_SIZE bits:
- 0 (CMD_AND): out = r1 & r2; OVERFLOW = 0.
- 1 (CMD_OR): out = r1 | r2; OVERFLOW = 0.
- 2 (CMD_XOR): out = r1 ^ r2; OVERFLOW = 0.
- 3 (CMD_ADD): {OVERFLOW, out} = r1 + r2, computed as an unsigned (WORD_SIZE+1)-bit sum. OVERFLOW is the carry out of the MSB.
- Any other value (possible only when CMD_SIZE > 2) is treated as CMD_ADD. There is no illegal-opcode flag.

Arithmetic rules:
- Operands are unsigned.
- The sum wraps modulo 2^WORD_SIZE in out, and the lost carry goes to OVERFLOW.
- No signed-overflow detection and no carry-in.

The combinational result is computed from the current inputs and captured into the out/OVERFLOW registers on every rising edge of clk when reset is low. No enable and no handshake: every cycle is a new operation.

## Timing

- Latency: exactly 1 cycle. The inputs sampled at edge N appear on out/OVERFLOW after edge N, and are held until edge N+1.
- Outputs come from registers only; there is no combinational path from the inputs to the outputs.
- Reset: if reset is high at a rising edge, out = 0 and OVERFLOW = 0 after that edge, regardless of the inputs.
- Outputs remain 0 for as long as reset stays high.
- Reset asserted mid-stream discards the in-flight operation.
- On the first edge with reset low, the inputs present at that edge are captured normally. There is no recovery bubble.
- Inputs changing between edges have no effect until the next edge. The inputs must meet setup/hold to clk.
- Back-to-back operations with a different opcode every cycle are fully supported at a throughput of one per cycle.

## Test plan

All cases use WORD_SIZE=2, CMD_SIZE=2; each check is made after the capturing edge.

- Reset: hold reset=1 for 2 cycles with opcode=3, r1=3, r2=3 -> out=0, OVERFLOW=0 throughout. Release reset -> the next edge gives out=2, OVERFLOW=1.
- Logic ops: r1=2'b10, r2=2'b11 with opcode 0, 1, 2 on consecutive cycles -> out = 2'b10, 2'b11, 2'b01 respectively, with OVERFLOW=0 each cycle and one-cycle latency.
- ADD without carry: opcode=3, r1=1, r2=2 -> out=3, OVERFLOW=0.
- ADD with wrap: opcode=3, r1=3, r2=1 -> out=0, OVERFLOW=1. Then r1=2, r2=2 -> out=0, OVERFLOW=1.
- Mid-stream reset: stream ADD r1=3, r2=3, and assert reset for one cycle -> the outputs go to 0 on that edge only. The following edge returns out=2, OVERFLOW=1.
- Random regression: 1000 cycles of random opcode/r1/r2. On each edge, compare against the golden model of the previous cycle's inputs (AND/OR/XOR with OVERFLOW=0; ADD checking {OVERFLOW,out} = r1+r2) -> zero mismatches.
